// File: rtl/note_window_filter_if.sv
// Sample-in / filtered-note-out bundle for note_window_filter.
interface note_window_filter_if;
  logic       sample_valid_in;
  logic [5:0] sample_note_in;
  logic [5:0] note_out;
  logic       note_valid_out;
  logic       busy_out;

  modport master (
    output sample_valid_in,
    output sample_note_in,
    input  note_out,
    input  note_valid_out,
    input  busy_out
  );

  modport slave (
    input  sample_valid_in,
    input  sample_note_in,
    output note_out,
    output note_valid_out,
    output busy_out
  );
endinterface

// File: rtl/note_window_filter.sv
// Mode-vote filter: collects WINDOW detector codes, then publishes the most frequent note or a rest.
// Optional NOTE_HOLD_EN: a new value is published only after winning two consecutive windows.
module note_window_filter #(
  parameter int unsigned WINDOW    = 64,
  parameter int unsigned NUM_NOTES = 22,
  parameter int unsigned MIN_COUNT = 16
) (
  input logic                 pixel_clk_in,
  input logic                 rst_in,
  note_window_filter_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(WINDOW + 1);
  localparam int unsigned IdxW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

  typedef enum logic [1:0] {StAccum, StScan, StPublish} state_e;

  state_e          state_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] bins_q [NUM_NOTES];
  logic [IdxW-1:0] scan_idx_q;
  logic [IdxW-1:0] best_idx_q;
  logic [CntW-1:0] best_cnt_q;
  logic [7:0]      drop_cnt_q;
  logic [5:0]      note_q;
  logic            note_valid_q;
  logic            busy_q;
`ifdef NOTE_HOLD_EN
  logic [5:0]      pend_q;
`endif

  logic            accept;
  logic            in_range;
  logic            last_sample;
  logic [IdxW-1:0] sample_idx;
  logic [5:0]      cand;

  // The PUBLISH edge already accepts the first sample of the next window.
  always_comb begin
    accept      = bus_io.sample_valid_in && (state_q != StScan);
    in_range    = bus_io.sample_note_in[5] && (32'(bus_io.sample_note_in[4:0]) < NUM_NOTES);
    sample_idx  = bus_io.sample_note_in[IdxW-1:0];
    last_sample = accept && (count_q == CntW'(WINDOW - 1));
    cand        = (best_cnt_q >= CntW'(MIN_COUNT)) ? {1'b1, 5'(best_idx_q)} : 6'd0;
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StAccum;
      count_q      <= '0;
      for (int unsigned i = 0; i < NUM_NOTES; i++) bins_q[i] <= '0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef NOTE_HOLD_EN
      pend_q       <= '0;
`endif
    end else begin
      note_valid_q <= 1'b0;

      if (accept) begin
        if (in_range) bins_q[sample_idx] <= bins_q[sample_idx] + CntW'(1);
        count_q <= last_sample ? '0 : count_q + CntW'(1);
      end

      unique case (state_q)
        StAccum: begin
          if (last_sample) begin
            state_q    <= StScan;
            busy_q     <= 1'b1;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
          end
        end
        StScan: begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if (bins_q[scan_idx_q] > best_cnt_q) begin
            best_cnt_q <= bins_q[scan_idx_q];
            best_idx_q <= scan_idx_q;
          end
          bins_q[scan_idx_q] <= '0;
          // Dropped-sample counter, debug visibility only.
          if (bus_io.sample_valid_in && (drop_cnt_q != 8'hff)) drop_cnt_q <= drop_cnt_q + 8'd1;
          if (scan_idx_q == IdxW'(NUM_NOTES - 1)) begin
            state_q <= StPublish;
          end else begin
            scan_idx_q <= scan_idx_q + IdxW'(1);
          end
        end
        StPublish: begin
`ifdef NOTE_HOLD_EN
          if (cand == pend_q) note_q <= cand;
          pend_q <= cand;
`else
          note_q <= cand;
`endif
          note_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StAccum;
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  assign bus_io.note_out       = note_q;
  assign bus_io.note_valid_out = note_valid_q;
  assign bus_io.busy_out       = busy_q;

endmodule

// File: tb/tb_note_window_filter.sv
// Directed bench for note_window_filter: per-cycle compare against a window-level vote model.
module tb_note_window_filter;

  localparam int unsigned WINDOW    = 64;
  localparam int unsigned NUM_NOTES = 22;
  localparam int unsigned MIN_COUNT = 16;

  localparam logic [5:0] C4 = 6'b100000;
  localparam logic [5:0] D4 = 6'b100010;
  localparam logic [5:0] E4 = 6'b100100;
  localparam logic [5:0] G4 = 6'b100111;
  localparam logic [5:0] A4 = 6'b101001;
  localparam logic [5:0] B4 = 6'b101011;
  localparam logic [5:0] RS = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  note_window_filter_if bus ();

  note_window_filter #(
    .WINDOW   (WINDOW),
    .NUM_NOTES(NUM_NOTES),
    .MIN_COUNT(MIN_COUNT)
  ) dut (
    .pixel_clk_in(clk),
    .rst_in      (rst),
    .bus_io      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window-level model: the vote is taken over the whole accepted window at once.
  function automatic logic [5:0] vote(input logic [5:0] w[$]);
    int cnt[32];
    int best = 0;
    int bidx = 0;
    foreach (cnt[i]) cnt[i] = 0;
    foreach (w[k]) if (w[k][5] && (int'(w[k][4:0]) < NUM_NOTES)) cnt[w[k][4:0]]++;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (cnt[i] > best) begin
        best = cnt[i];
        bidx = i;
      end
    end
    return (best >= MIN_COUNT) ? {1'b1, 5'(bidx)} : 6'd0;
  endfunction

  logic [5:0] win[$];
  int         wait_cnt = 0;
  logic [5:0] m_note   = '0;
  logic [5:0] m_pend   = '0;
  logic [5:0] m_cand   = '0;
  logic       m_valid  = 1'b0;
  logic       m_busy   = 1'b0;
  bit         m_acc;
  bit         model_on = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      win.delete();
      wait_cnt = 0;
      m_note   = '0;
      m_pend   = '0;
      m_valid  = 1'b0;
      m_busy   = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_acc   = bus.sample_valid_in;
      if (wait_cnt > 1) begin
        wait_cnt--;
        m_acc = 1'b0;
      end else if (wait_cnt == 1) begin
        wait_cnt = 0;
        m_valid  = 1'b1;
        m_busy   = 1'b0;
`ifdef NOTE_HOLD_EN
        if (m_cand == m_pend) m_note = m_cand;
        m_pend = m_cand;
`else
        m_note = m_cand;
`endif
      end
      if (m_acc) begin
        win.push_back(bus.sample_note_in);
        if (win.size() == WINDOW) begin
          m_cand = vote(win);
          win.delete();
          wait_cnt = NUM_NOTES + 1;
          m_busy   = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_on && !rst) begin
      check("note_out vs model", 8'(bus.note_out), 8'(m_note));
      check("note_valid_out vs model", 8'(bus.note_valid_out), 8'(m_valid));
      check("busy_out vs model", 8'(bus.busy_out), 8'(m_busy));
    end
  end

  task automatic feed(input logic [5:0] code, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sample_valid_in = 1'b1;
      bus.sample_note_in  = code;
    end
  endtask

  // Called right after the last feed; optionally strobes scode every cycle while waiting.
  task automatic wait_pub(input bit strobe, input logic [5:0] scode,
                          output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen        = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.busy_out) busy_cycles++;
      if (bus.note_valid_out) seen = 1'b1;
      bus.sample_valid_in = strobe && !seen;
      bus.sample_note_in  = scode;
      if (!seen) @(negedge clk);
    end
  endtask

  task automatic window_check(input string name, input logic [5:0] exp_plain,
                              input logic [5:0] exp_hold);
    int bc;
    bit seen;
    wait_pub(1'b0, RS, bc, seen);
    check({name, " publish seen"}, 8'(seen), 8'd1);
`ifdef NOTE_HOLD_EN
    check(name, 8'(bus.note_out), 8'(exp_hold));
`else
    check(name, 8'(bus.note_out), 8'(exp_plain));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bc;
    bit  seen;
    bus.sample_valid_in = 1'b0;
    bus.sample_note_in  = '0;

    repeat (2) @(negedge clk);
    check("reset note_out", 8'(bus.note_out), 8'd0);
    check("reset note_valid_out", 8'(bus.note_valid_out), 8'd0);
    check("reset busy_out", 8'(bus.busy_out), 8'd0);
    rst      = 1'b0;
    model_on = 1'b1;

    feed(G4, 64);
    wait_pub(1'b0, RS, bc, seen);
    check("G4 window publish seen", 8'(seen), 8'd1);
    check("G4 busy cycles", 8'(bc), 8'd23);
`ifdef NOTE_HOLD_EN
    check("G4 window", 8'(bus.note_out), 8'd0);
`else
    check("G4 window", 8'(bus.note_out), 8'(G4));
`endif
    @(negedge clk);
    check("note_valid one-cycle", 8'(bus.note_valid_out), 8'd0);

    feed(A4, 40);
    feed(B4, 24);
    window_check("A4 majority", A4, RS);

    feed(D4, 32);
    feed(E4, 32);
    window_check("D4/E4 tie", D4, RS);

    feed(C4, 15);
    feed(RS, 49);
    window_check("below MIN_COUNT", RS, RS);

    feed(6'b111111, 64);
    window_check("out of range", RS, RS);

    // Strobes during SCAN are dropped; the strobe on the PUBLISH edge opens the next window.
    feed(G4, 64);
    wait_pub(1'b1, C4, bc, seen);
    check("scan strobe publish seen", 8'(seen), 8'd1);
`ifdef NOTE_HOLD_EN
    check("scan strobe window", 8'(bus.note_out), 8'd0);
`else
    check("scan strobe window", 8'(bus.note_out), 8'(G4));
`endif
    feed(C4, 15);
    feed(RS, 48);
    window_check("post-publish sample counted", C4, RS);

    feed(G4, 64);
    @(negedge clk);
    bus.sample_valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset note_out", 8'(bus.note_out), 8'd0);
    check("async reset note_valid_out", 8'(bus.note_valid_out), 8'd0);
    check("async reset busy_out", 8'(bus.busy_out), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    feed(E4, 40);
    feed(RS, 24);
    window_check("after reset no stale bins", E4, RS);

    feed(G4, 64);
    window_check("hold seq w1 G4", G4, RS);
    feed(G4, 64);
    window_check("hold seq w2 G4", G4, G4);
    feed(A4, 64);
    window_check("hold seq w3 A4", A4, G4);
    feed(A4, 64);
    window_check("hold seq w4 A4", A4, A4);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
